sata_dma_burst_seq: RTL



---
 rtl/sata_dma_burst_seq_if.sv | 26 ++
 rtl/sata_dma_burst_seq.sv | 136 +++++++++++++
 2 files changed

// File: rtl/sata_dma_burst_seq_if.sv
// Command/beat handshake bundle between the SATA DMA register side, the burst
// sequencer and the AXI-HP adapter. The master modport is the sequencer's view.
interface sata_dma_burst_seq_if;
  logic [31:7] mem_address;
  logic [31:0] sector_cnt;
  logic        dma_type;
  logic        dma_start;
  logic        busy;
  logic        dma_done;
  logic [31:7] cmd_addr;
  logic        cmd_type;
  logic        cmd_val;
  logic        cmd_ack;
  logic        beat;
  logic [3:0]  outstanding;

  modport master (
    input  mem_address, sector_cnt, dma_type, dma_start, cmd_ack, beat,
    output busy, dma_done, cmd_addr, cmd_type, cmd_val, outstanding
  );

  modport slave (
    output mem_address, sector_cnt, dma_type, dma_start, cmd_ack, beat,
    input  busy, dma_done, cmd_addr, cmd_type, cmd_val, outstanding
  );
endinterface

// File: rtl/sata_dma_burst_seq.sv
// Splits a sector-count DMA transfer into 128-byte (16 x 64-bit beat) burst
// commands, limits bursts in flight and pulses dma_done after the last beat.
module sata_dma_burst_seq #(
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned CNT_W           = 34
) (
  input logic                 hclk,
  input logic                 rst,
  sata_dma_burst_seq_if.master bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [3:0] MAX_OUT = 4'(MAX_OUTSTANDING);

  logic [1:0]       state_q, state_d;
  logic [24:0]      cmd_addr_q, cmd_addr_d;
  logic             cmd_type_q, cmd_type_d;
  logic             cmd_val_q, cmd_val_d;
  logic             busy_q, busy_d;
  logic             dma_done_q, dma_done_d;
  logic [CNT_W-1:0] to_issue_q, to_issue_d;
  logic [CNT_W-1:0] to_complete_q, to_complete_d;
  logic [3:0]       outstanding_q, outstanding_d;
  logic [3:0]       beat_cnt_q, beat_cnt_d;

  logic             active;
  logic             accept;
  logic             beat_ok;
  logic             burst_done;

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    state_d       = state_q;
    cmd_addr_d    = cmd_addr_q;
    cmd_type_d    = cmd_type_q;
    to_issue_d    = to_issue_q;
    to_complete_d = to_complete_q;
    outstanding_d = outstanding_q;
    beat_cnt_d    = beat_cnt_q;

    active     = (state_q == ST_RUN) || (state_q == ST_FLUSH);
    accept     = cmd_val_q && bus.cmd_ack;
    // A beat with nothing in flight is a protocol error and must not disturb the count.
    beat_ok    = active && bus.beat && (outstanding_q != 4'd0);
    burst_done = beat_ok && (beat_cnt_q == 4'hF);

    if (accept) begin
      cmd_addr_d = cmd_addr_q + 25'd1;
      to_issue_d = to_issue_q - CNT_W'(1);
    end
    if (beat_ok) begin
      beat_cnt_d = beat_cnt_q + 4'd1;
    end
    if (burst_done) begin
      to_complete_d = to_complete_q - CNT_W'(1);
    end

    case ({accept, burst_done})
      2'b10:   outstanding_d = outstanding_q + 4'd1;
      2'b01:   outstanding_d = outstanding_q - 4'd1;
      default: outstanding_d = outstanding_q;
    endcase

    case (state_q)
      ST_IDLE: begin
        if (bus.dma_start) begin
          cmd_addr_d    = bus.mem_address;
          cmd_type_d    = bus.dma_type;
          to_issue_d    = CNT_W'({bus.sector_cnt, 2'b00});
          to_complete_d = CNT_W'({bus.sector_cnt, 2'b00});
          outstanding_d = 4'd0;
          beat_cnt_d    = 4'd0;
          // A zero-length transfer still walks through FLUSH so dma_done lands two cycles after start.
          state_d       = (bus.sector_cnt == 32'd0) ? ST_FLUSH : ST_RUN;
        end
      end
      ST_RUN: begin
        if (to_issue_d == '0) state_d = ST_FLUSH;
      end
      ST_FLUSH: begin
        if (to_complete_d == '0) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Gated by the current state so cmd_val first rises one cycle after RUN entry,
    // but by next-cycle counters so it can stay high across back-to-back accepts.
    cmd_val_d  = (state_q == ST_RUN) && (to_issue_d != '0) && (outstanding_d < MAX_OUT);
    busy_d     = (state_d != ST_IDLE);
    dma_done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge hclk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q       <= ST_IDLE;
      cmd_addr_q    <= '0;
      cmd_type_q    <= 1'b0;
      cmd_val_q     <= 1'b0;
      busy_q        <= 1'b0;
      dma_done_q    <= 1'b0;
      to_issue_q    <= '0;
      to_complete_q <= '0;
      outstanding_q <= '0;
      beat_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      cmd_addr_q    <= cmd_addr_d;
      cmd_type_q    <= cmd_type_d;
      cmd_val_q     <= cmd_val_d;
      busy_q        <= busy_d;
      dma_done_q    <= dma_done_d;
      to_issue_q    <= to_issue_d;
      to_complete_q <= to_complete_d;
      outstanding_q <= outstanding_d;
      beat_cnt_q    <= beat_cnt_d;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.dma_done    = dma_done_q;
  assign bus.cmd_addr    = cmd_addr_q;
  assign bus.cmd_type    = cmd_type_q;
  assign bus.cmd_val     = cmd_val_q;
  assign bus.outstanding = outstanding_q;

endmodule
